// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/PC sequencing slice.
//   - seq_state_e   : sequencer FSM state encoding
//   - INSTR_W       : instruction word width
//   - *_VECTOR_DEF  : default reset / exception PC values
//   - word_align()  : clears the byte-offset bits of an address
package mips_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection.
// Ports:
//   pc            in  : current PC
//   jump          in  : jump/jr redirect request (highest priority)
//   jump_target   in  : jump destination (low two bits ignored)
//   branch_taken  in  : taken-branch redirect request
//   branch_target in  : branch destination (low two bits ignored)
//   next_pc       out : jump_target, else branch_target, else pc+4 (wraps)
module next_pc_mux
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc + 32'd4;
        if (jump) begin
            next_pc = word_align(jump_target);
        end else if (branch_taken) begin
            next_pc = word_align(branch_target);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: issues one fetch at a time, holds the fetched
// word for decode until accepted, then advances the PC (sequential, branch or
// jump), with exception redirect and a terminal halt state.
// Ports:
//   clk_in, rst               : clock, async active-high reset
//   imem_req/addr/ack/rdata   : instruction memory fetch interface
//   instr, instr_valid,
//   instr_ready               : decode handshake
//   branch_taken/target,
//   jump/jump_target, halt    : sampled on handshake
//   exc                       : exception request (ignored when halted)
//   pc, retired, halted       : status
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic               clk_in,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    input  logic               exc,
    input  logic               halt,
    output logic [31:0]        pc,
    output logic [31:0]        retired,
    output logic               halted
);

    seq_state_e         state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        retired_q, retired_d;
    logic               exc_pend_q, exc_pend_d;
    logic [31:0]        next_pc;

    next_pc_mux u_next_pc_mux (
        .pc            (pc_q),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            instr_q    <= '0;
            retired_q  <= '0;
            exc_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            retired_q  <= retired_d;
            exc_pend_q <= exc_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        exc_pend_d  = exc_pend_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (exc) begin
                    pc_d = EXC_VECTOR;
                end
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    // An exception seen now or earlier in this fetch drops the
                    // returned word and restarts fetching at the vector.
                    if (exc || exc_pend_q) begin
                        pc_d       = EXC_VECTOR;
                        exc_pend_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = ST_HOLD;
                    end
                end else if (exc) begin
                    // The request cannot be withdrawn; keep the address and
                    // remember the exception until the ack arrives.
                    exc_pend_d = 1'b1;
                end
            end

            ST_HOLD: begin
                instr_valid = 1'b1;
                if (exc) begin
                    pc_d    = EXC_VECTOR;
                    state_d = ST_FETCH;
                end else if (instr_ready) begin
                    retired_d = retired_q + 32'd1;
                    pc_d      = next_pc;
                    state_d   = halt ? ST_HALTED : ST_FETCH;
                end
            end

            ST_HALTED: begin
                halted = 1'b1;
            end
        endcase
    end

    assign imem_addr = imem_req ? pc_q : '0;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import mips_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        halted;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned cycle    = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_retired;

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0080)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exc           (exc),
        .halt          (halt),
        .pc            (pc),
        .retired       (retired),
        .halted        (halted)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        cycle++;
    endtask

    task automatic clear_inputs();
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        exc           = 1'b0;
        halt          = 1'b0;
    endtask

    // Waits (bounded) for a fetch request and compares its address against
    // the next scoreboard entry.
    task automatic start_fetch(input string tag, output logic [31:0] exp_a);
        int unsigned n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_req"}, 32'(imem_req), 32'd1);
        check_eq({tag, "_sb"}, 32'(exp_addr_q.size()), 32'd1);
        exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hXXXX_XXXX;
        check_eq({tag, "_addr"}, imem_addr, exp_a);
    endtask

    task automatic fetch(input string tag, input int unsigned delay, input logic [31:0] data);
        logic [31:0] exp_a;
        start_fetch(tag, exp_a);
        for (int unsigned i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            tick();
            check_eq({tag, "_stable"}, imem_addr, exp_a);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        exp_instr_q.push_back(data);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic handshake(input string tag, input logic br, input logic [31:0] bt,
                             input logic j, input logic [31:0] jt, input logic hlt);
        int unsigned n = 0;
        logic [31:0] exp_i;
        while (instr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
        exp_i = (exp_instr_q.size() > 0) ? exp_instr_q.pop_front() : 32'hXXXX_XXXX;
        check_eq({tag, "_instr"}, instr, exp_i);
        if (j)       model_pc = {jt[31:2], 2'b00};
        else if (br) model_pc = {bt[31:2], 2'b00};
        else         model_pc = model_pc + 32'd4;
        model_retired = model_retired + 32'd1;
        if (!hlt) exp_addr_q.push_back(model_pc);
        instr_ready   = 1'b1;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        halt          = hlt;
        tick();
        clear_inputs();
        check_eq({tag, "_retired"}, retired, model_retired);
        check_eq({tag, "_pc"}, pc, model_pc);
    endtask

    initial begin
        logic [31:0] exp_a;
        int unsigned c0;

        clear_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        tick();
        tick();
        check_eq("rst_req",     32'(imem_req), 32'd0);
        check_eq("rst_valid",   32'(instr_valid), 32'd0);
        check_eq("rst_pc",      pc, 32'h0000_0000);
        check_eq("rst_instr",   instr, 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        check_eq("rst_halted",  32'(halted), 32'd0);
        rst = 1'b0;
        model_pc      = 32'h0000_0000;
        model_retired = 32'd0;
        exp_addr_q.push_back(32'h0000_0000);
        check_eq("idle_req", 32'(imem_req), 32'd0);

        // Back-to-back ack, always ready: 0x0, 0x4, 0x8 at one retire / 2 cycles.
        fetch("f0", 0, 32'h1111_0000);
        handshake("h0", 1'b0, '0, 1'b0, '0, 1'b0);
        c0 = cycle;
        fetch("f1", 0, 32'h1111_0004);
        handshake("h1", 1'b0, '0, 1'b0, '0, 1'b0);
        check_eq("rate_1", cycle - c0, 32'd2);
        c0 = cycle;
        fetch("f2", 0, 32'h1111_0008);
        handshake("h2", 1'b0, '0, 1'b0, '0, 1'b0);
        check_eq("rate_2", cycle - c0, 32'd2);
        check_eq("retired_3", retired, 32'd3);

        // Jump beats branch; branch target is word aligned.
        fetch("f3", 2, 32'h2222_000C);
        handshake("h3", 1'b1, 32'h0000_0103, 1'b1, 32'h0000_0200, 1'b0);
        check_eq("jump_pri", pc, 32'h0000_0200);
        fetch("f4", 0, 32'h2222_0200);
        handshake("h4", 1'b1, 32'h0000_0103, 1'b0, '0, 1'b0);
        check_eq("branch_only", pc, 32'h0000_0100);

        // Exception in HOLD overrides handshake, redirect and halt.
        fetch("f5", 1, 32'h3333_0100);
        exc = 1'b1; instr_ready = 1'b1; halt = 1'b1; jump = 1'b1; jump_target = 32'h300;
        tick();
        clear_inputs();
        check_eq("hexc_valid",   32'(instr_valid), 32'd0);
        check_eq("hexc_retired", retired, model_retired);
        check_eq("hexc_halted",  32'(halted), 32'd0);
        void'(exp_instr_q.pop_front());
        model_pc = 32'h0000_0080;
        exp_addr_q.push_back(model_pc);
        fetch("f6", 0, 32'h4444_0080);
        handshake("h6", 1'b0, '0, 1'b1, 32'h0000_0400, 1'b0);

        // Exception mid-fetch, ack three cycles later with 0xDEADBEEF.
        start_fetch("f_exc", exp_a);
        exc = 1'b1;
        tick();
        exc = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            tick();
            check_eq("pend_addr",  imem_addr, 32'h0000_0400);
            check_eq("pend_valid", 32'(instr_valid), 32'd0);
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        clear_inputs();
        check_eq("pend_redirect", imem_addr, 32'h0000_0080);
        check_eq("pend_retired",  retired, model_retired);
        for (int unsigned i = 0; i < 2; i++) begin
            check_eq("pend_novalid", 32'(instr_valid), 32'd0);
            tick();
        end
        check_eq("pend_noinstr", instr, 32'h4444_0080);
        model_pc = 32'h0000_0080;
        exp_addr_q.push_back(model_pc);

        // Exception coinciding with ack: data dropped, refetch at the vector.
        start_fetch("f_exc_ack", exp_a);
        exc = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        clear_inputs();
        check_eq("excack_valid", 32'(instr_valid), 32'd0);
        check_eq("excack_req",   32'(imem_req), 32'd1);
        exp_addr_q.push_back(model_pc);

        // Unaligned jump target, then +4 wrap at the top of the address space.
        fetch("f7", 0, 32'h5555_0080);
        handshake("h7", 1'b0, '0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        check_eq("top_pc", pc, 32'hFFFF_FFFC);
        fetch("f8", 1, 32'h5555_FFFC);
        handshake("h8", 1'b0, '0, 1'b0, '0, 1'b0);
        check_eq("wrap_pc", pc, 32'h0000_0000);

        // Halt: sticky, exception ignored, only reset leaves it.
        fetch("f9", 0, 32'h6666_0000);
        handshake("h9", 1'b0, '0, 1'b0, '0, 1'b1);
        check_eq("halt_halted", 32'(halted), 32'd1);
        check_eq("halt_req",    32'(imem_req), 32'd0);
        check_eq("halt_valid",  32'(instr_valid), 32'd0);
        exc = 1'b1;
        tick();
        tick();
        exc = 1'b0;
        check_eq("halt_exc_halted", 32'(halted), 32'd1);
        check_eq("halt_exc_req",    32'(imem_req), 32'd0);
        check_eq("halt_exc_pc",     pc, 32'h0000_0004);
        rst = 1'b1;
        #2;
        check_eq("halt_rst_halted", 32'(halted), 32'd0);
        check_eq("halt_rst_pc",     pc, 32'h0000_0000);
        rst = 1'b0;
        model_pc      = 32'h0000_0000;
        model_retired = 32'd0;
        exp_addr_q.push_back(model_pc);
        fetch("f10", 0, 32'h7777_0000);
        handshake("h10", 1'b0, '0, 1'b0, '0, 1'b0);

        // Asynchronous reset in the middle of HOLD.
        fetch("f11", 0, 32'h7777_0004);
        check_eq("hold_valid", 32'(instr_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        check_eq("async_valid",   32'(instr_valid), 32'd0);
        check_eq("async_pc",      pc, 32'h0000_0000);
        check_eq("async_instr",   instr, 32'd0);
        check_eq("async_retired", retired, 32'd0);
        void'(exp_instr_q.pop_front());
        exp_addr_q.delete();

        // Reset mid-fetch, then a late ack lands while IDLE and is ignored.
        tick();
        rst = 1'b0;
        tick();
        check_eq("mid_req", 32'(imem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_req", 32'(imem_req), 32'd0);
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hABCD_0000;
        tick();
        clear_inputs();
        check_eq("late_ack_valid", 32'(instr_valid), 32'd0);
        check_eq("late_ack_req",   32'(imem_req), 32'd1);
        model_pc      = 32'h0000_0000;
        model_retired = 32'd0;
        exp_addr_q.push_back(model_pc);
        fetch("f12", 0, 32'h8888_0000);
        handshake("h12", 1'b0, '0, 1'b0, '0, 1'b0);
        check_eq("final_retired", retired, 32'd1);
        check_eq("sb_drain_instr", 32'(exp_instr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
